// File: rtl/ir_pkg.sv
// ir_pkg: default instruction field widths and field-slice helpers shared by
// the instruction register and the control sequencer.
package ir_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned CC_W   = 4;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned IW     = OP_W + CC_W + 2 * ADDR_W;

  // Widest instruction word the slice helpers can handle
  localparam int unsigned MAX_W  = 64;

  typedef logic [MAX_W-1:0] word_t;

  // Low-order mask of w ones
  function automatic word_t field_mask(input int unsigned w);
    return (word_t'(1) << w) - word_t'(1);
  endfunction

  // Word layout, MSB first: op | cc | s_a | de_a
  function automatic word_t get_op(input word_t w, input int unsigned op_w,
                                   input int unsigned cc_w, input int unsigned addr_w);
    return (w >> (cc_w + 2 * addr_w)) & field_mask(op_w);
  endfunction

  function automatic word_t get_cc(input word_t w, input int unsigned cc_w,
                                   input int unsigned addr_w);
    return (w >> (2 * addr_w)) & field_mask(cc_w);
  endfunction

  function automatic word_t get_sa(input word_t w, input int unsigned addr_w);
    return (w >> addr_w) & field_mask(addr_w);
  endfunction

  function automatic word_t get_dea(input word_t w, input int unsigned addr_w);
    return w & field_mask(addr_w);
  endfunction

endpackage

// File: rtl/ir_fifo.sv
// ir_fifo: circular prefetch queue of DEPTH words (DEPTH a power of two).
// clr empties the queue and takes priority over push and pop.
module ir_fifo
  import ir_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;

  assign dout  = r_mem[r_rptr];
  assign level = r_level;
  assign full  = (r_level == LW'(DEPTH));
  assign empty = (r_level == '0);

  // Storage write; contents need no reset since level gates visibility
  always_ff @(posedge clk) begin
    if (push && !clr) r_mem[r_wptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (push) r_wptr <= r_wptr + 1'b1;
      if (pop)  r_rptr <= r_rptr + 1'b1;
      case ({push, pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/ir_queue.sv
// ir_queue: instruction register fed by a prefetch queue. The current
// instruction is held in registered op/cc/s_a/de_a fields behind ir_fifo.
// Optional build macro IR_QUEUE_BYPASS_EN: an accepted push into an empty
// queue with a free current stage loads the fields directly (1-cycle latency).
module ir_queue
  import ir_pkg::*;
#(
  parameter  int unsigned OP_W   = ir_pkg::OP_W,
  parameter  int unsigned CC_W   = ir_pkg::CC_W,
  parameter  int unsigned ADDR_W = ir_pkg::ADDR_W,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned IW     = OP_W + CC_W + 2 * ADDR_W,
  localparam int unsigned LW     = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              ir_cmd,
  input  logic [IW-1:0]     ir_datain,
  output logic              ir_ready,
  input  logic              ir_next,
  output logic              ir_valid,
  output logic [OP_W-1:0]   op,
  output logic [CC_W-1:0]   cc,
  output logic [ADDR_W-1:0] s_a,
  output logic [ADDR_W-1:0] de_a,
  output logic [LW-1:0]     level,
  output logic              ovf
);

  logic              r_valid;
  logic              r_ovf;
  logic [OP_W-1:0]   r_op;
  logic [CC_W-1:0]   r_cc;
  logic [ADDR_W-1:0] r_sa;
  logic [ADDR_W-1:0] r_dea;

  logic [IW-1:0]     w_dout;
  logic [LW-1:0]     w_level;
  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_slot;
  logic              w_bypass;
  logic              w_pop;
  logic              w_push;
  logic              w_load;
  logic [IW-1:0]     w_load_word;
  word_t             w_word;

  assign ir_ready = !w_full;
  assign w_accept = ir_cmd && ir_ready;
  assign w_slot   = !r_valid || ir_next;

`ifdef IR_QUEUE_BYPASS_EN
  assign w_bypass = w_accept && w_slot && w_empty && !flush;
`else
  assign w_bypass = 1'b0;
`endif

  // Flush suppresses every queue and field update in its cycle
  assign w_pop       = w_slot && !w_empty && !flush;
  assign w_push      = w_accept && !w_bypass && !flush;
  assign w_load      = w_pop || w_bypass;
  assign w_load_word = w_pop ? w_dout : ir_datain;
  assign w_word      = word_t'(w_load_word);

  ir_fifo #(
    .WIDTH (IW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clock),
    .rst   (reset),
    .clr   (flush),
    .push  (w_push),
    .pop   (w_pop),
    .din   (ir_datain),
    .dout  (w_dout),
    .level (w_level),
    .full  (w_full),
    .empty (w_empty)
  );

  // Current-instruction valid flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        r_valid <= 1'b0;
    else if (flush)   r_valid <= 1'b0;
    else if (w_load)  r_valid <= 1'b1;
    else if (ir_next) r_valid <= 1'b0;
  end

  // Sticky overflow on a push attempted while the queue is full
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                     r_ovf <= 1'b0;
    else if (flush)                r_ovf <= 1'b0;
    else if (ir_cmd && !ir_ready)  r_ovf <= 1'b1;
  end

  // Field registers change only on a load; flush leaves them stale
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_op  <= '0;
      r_cc  <= '0;
      r_sa  <= '0;
      r_dea <= '0;
    end else if (w_load) begin
      r_op  <= OP_W'(get_op(w_word, OP_W, CC_W, ADDR_W));
      r_cc  <= CC_W'(get_cc(w_word, CC_W, ADDR_W));
      r_sa  <= ADDR_W'(get_sa(w_word, ADDR_W));
      r_dea <= ADDR_W'(get_dea(w_word, ADDR_W));
    end
  end

  assign ir_valid = r_valid;
  assign op       = r_op;
  assign cc       = r_cc;
  assign s_a      = r_sa;
  assign de_a     = r_dea;
  assign level    = w_level;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_ir_queue.sv
// tb_ir_queue: directed self-checking bench for ir_queue at default widths
// (32-bit word, DEPTH=4). Honours IR_QUEUE_BYPASS_EN for latency-dependent
// expectations.
module tb_ir_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        ir_cmd;
  logic [31:0] ir_datain;
  logic        ir_ready;
  logic        ir_next;
  logic        ir_valid;
  logic [3:0]  op;
  logic [3:0]  cc;
  logic [11:0] s_a;
  logic [11:0] de_a;
  logic [2:0]  level;
  logic        ovf;

  logic [32:0] obs;
  logic [38:0] rst_obs;
  localparam logic [38:0] RST_VEC = {33'h0, 3'd0, 1'b0, 1'b1};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  assign obs     = {ir_valid, op, cc, s_a, de_a};
  assign rst_obs = {obs, level, ovf, ir_ready};

  ir_queue #(
    .OP_W   (4),
    .CC_W   (4),
    .ADDR_W (12),
    .DEPTH  (4)
  ) u_dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .ir_cmd    (ir_cmd),
    .ir_datain (ir_datain),
    .ir_ready  (ir_ready),
    .ir_next   (ir_next),
    .ir_valid  (ir_valid),
    .op        (op),
    .cc        (cc),
    .s_a       (s_a),
    .de_a      (de_a),
    .level     (level),
    .ovf       (ovf)
  );

  function automatic logic [31:0] wd(input int k);
    return 32'h0123_4567 ^ (32'(k) * 32'h9E37_79B9);
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; flush = 1'b0; ir_cmd = 1'b0; ir_next = 1'b0; ir_datain = '0;
    #2;
    n_checks++;
    if (rst_obs !== RST_VEC) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", rst_obs, RST_VEC);
    end
    tick; tick;
    reset = 1'b0;
    tick;
    n_checks++;
    if (rst_obs !== RST_VEC) begin
      n_fail++; $display("FAIL reset_idle: got %h expected %h", rst_obs, RST_VEC);
    end
  endtask

  task automatic test_latency;
    ir_datain = 32'h1A3C_5F01; ir_cmd = 1'b1;
    tick;
    ir_cmd = 1'b0;
`ifdef IR_QUEUE_BYPASS_EN
    n_checks++;
    if (obs !== {1'b1, 32'h1A3C_5F01} || level !== 3'd0) begin
      n_fail++; $display("FAIL lat_edge1: got %h lvl %0d expected %h lvl 0", obs, level, {1'b1, 32'h1A3C_5F01});
    end
`else
    n_checks++;
    if (ir_valid !== 1'b0 || level !== 3'd1) begin
      n_fail++; $display("FAIL lat_edge1: got valid %b lvl %0d expected valid 0 lvl 1", ir_valid, level);
    end
`endif
    tick;
    n_checks++;
    if (obs !== {1'b1, 4'h1, 4'hA, 12'h3C5, 12'hF01} || level !== 3'd0) begin
      n_fail++; $display("FAIL lat_fields: got %h lvl %0d expected %h lvl 0", obs, level, {1'b1, 4'h1, 4'hA, 12'h3C5, 12'hF01});
    end
    ir_next = 1'b1;
    tick;
    n_checks++;
    if (ir_valid !== 1'b0) begin
      n_fail++; $display("FAIL lat_consume: got valid %b expected 0", ir_valid);
    end
    tick;
    ir_next = 1'b0;
    n_checks++;
    if (ir_valid !== 1'b0 || level !== 3'd0) begin
      n_fail++; $display("FAIL next_idle: got valid %b lvl %0d expected valid 0 lvl 0", ir_valid, level);
    end
  endtask

  task automatic test_fill;
    for (int k = 0; k < 5; k++) begin
      ir_cmd = 1'b1; ir_datain = wd(k);
      tick;
    end
    n_checks++;
    if (obs !== {1'b1, wd(0)} || level !== 3'd4 || ir_ready !== 1'b0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL fill_full: got %h lvl %0d rdy %b ovf %b expected %h lvl 4 rdy 0 ovf 0",
                         obs, level, ir_ready, ovf, {1'b1, wd(0)});
    end
    ir_datain = wd(5);
    tick;
    ir_cmd = 1'b0;
    n_checks++;
    if (ovf !== 1'b1 || level !== 3'd4 || obs !== {1'b1, wd(0)}) begin
      n_fail++; $display("FAIL fill_ovf: got ovf %b lvl %0d %h expected ovf 1 lvl 4 %h", ovf, level, obs, {1'b1, wd(0)});
    end
  endtask

  task automatic test_drain;
    ir_next = 1'b1;
    #1;
    n_checks++;
    if (ir_ready !== 1'b0) begin
      n_fail++; $display("FAIL ready_full_load: got %b expected 0", ir_ready);
    end
    for (int k = 1; k < 5; k++) begin
      tick;
      n_checks++;
      if (obs !== {1'b1, wd(k)} || level !== 3'(4 - k)) begin
        n_fail++; $display("FAIL drain_%0d: got %h lvl %0d expected %h lvl %0d", k, obs, level, {1'b1, wd(k)}, 4 - k);
      end
    end
    tick;
    ir_next = 1'b0;
    n_checks++;
    if (ir_valid !== 1'b0 || level !== 3'd0 || ovf !== 1'b1) begin
      n_fail++; $display("FAIL drain_end: got valid %b lvl %0d ovf %b expected valid 0 lvl 0 ovf 1", ir_valid, level, ovf);
    end
  endtask

  task automatic test_flush;
    for (int k = 0; k < 4; k++) begin
      ir_cmd = 1'b1; ir_datain = wd(10 + k);
      tick;
    end
    ir_cmd = 1'b0;
    n_checks++;
    if (level !== 3'd3 || obs !== {1'b1, wd(10)}) begin
      n_fail++; $display("FAIL flush_setup: got lvl %0d %h expected lvl 3 %h", level, obs, {1'b1, wd(10)});
    end
    flush = 1'b1; ir_cmd = 1'b1; ir_datain = wd(99); ir_next = 1'b1;
    tick;
    flush = 1'b0; ir_cmd = 1'b0; ir_next = 1'b0;
    n_checks++;
    if (level !== 3'd0 || ir_valid !== 1'b0 || ovf !== 1'b0 || ir_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_state: got lvl %0d valid %b ovf %b rdy %b expected lvl 0 valid 0 ovf 0 rdy 1",
                         level, ir_valid, ovf, ir_ready);
    end
    n_checks++;
    if (obs[31:0] !== wd(10)) begin
      n_fail++; $display("FAIL flush_stale: got %h expected %h", obs[31:0], wd(10));
    end
    tick; tick;
    n_checks++;
    if (ir_valid !== 1'b0 || level !== 3'd0) begin
      n_fail++; $display("FAIL flush_drop: got valid %b lvl %0d expected valid 0 lvl 0", ir_valid, level);
    end
  endtask

  task automatic test_stream;
    for (int k = 0; k < 20; k++) begin
      ir_cmd = 1'b1; ir_datain = wd(20 + k); ir_next = 1'b1;
      tick;
`ifdef IR_QUEUE_BYPASS_EN
      n_checks++;
      if (level !== 3'd0 || obs !== {1'b1, wd(20 + k)}) begin
        n_fail++; $display("FAIL stream_%0d: got lvl %0d %h expected lvl 0 %h", k, level, obs, {1'b1, wd(20 + k)});
      end
`else
      n_checks++;
      if (level !== 3'd1) begin
        n_fail++; $display("FAIL stream_lvl_%0d: got %0d expected 1", k, level);
      end
      if (k == 0) begin
        n_checks++;
        if (ir_valid !== 1'b0) begin
          n_fail++; $display("FAIL stream_first: got valid %b expected 0", ir_valid);
        end
      end else begin
        n_checks++;
        if (obs !== {1'b1, wd(19 + k)}) begin
          n_fail++; $display("FAIL stream_%0d: got %h expected %h", k, obs, {1'b1, wd(19 + k)});
        end
      end
`endif
    end
    ir_cmd = 1'b0;
    tick;
`ifdef IR_QUEUE_BYPASS_EN
    n_checks++;
    if (ir_valid !== 1'b0 || level !== 3'd0) begin
      n_fail++; $display("FAIL stream_tail: got valid %b lvl %0d expected valid 0 lvl 0", ir_valid, level);
    end
`else
    n_checks++;
    if (obs !== {1'b1, wd(39)} || level !== 3'd0) begin
      n_fail++; $display("FAIL stream_tail: got %h lvl %0d expected %h lvl 0", obs, level, {1'b1, wd(39)});
    end
`endif
    tick;
    ir_next = 1'b0;
    n_checks++;
    if (ir_valid !== 1'b0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL stream_end: got valid %b ovf %b expected valid 0 ovf 0", ir_valid, ovf);
    end
  endtask

  task automatic test_async_reset;
    for (int k = 0; k < 3; k++) begin
      ir_cmd = 1'b1; ir_datain = wd(50 + k);
      tick;
    end
    ir_cmd = 1'b0;
    n_checks++;
    if (level !== 3'd2 || obs !== {1'b1, wd(50)}) begin
      n_fail++; $display("FAIL areset_setup: got lvl %0d %h expected lvl 2 %h", level, obs, {1'b1, wd(50)});
    end
    #3;
    reset = 1'b1;
    #1;
    n_checks++;
    if (rst_obs !== RST_VEC) begin
      n_fail++; $display("FAIL areset_now: got %h expected %h", rst_obs, RST_VEC);
    end
    #2;
    reset = 1'b0;
    tick;
    n_checks++;
    if (ir_valid !== 1'b0 || level !== 3'd0) begin
      n_fail++; $display("FAIL areset_lost: got valid %b lvl %0d expected valid 0 lvl 0", ir_valid, level);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill();
    test_drain();
    test_flush();
    test_stream();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ir_queue.md
# ir_queue

Parametrised instruction register with a prefetch queue; successor to the single-entry instruction latch. Buffers up to DEPTH fetched instruction words behind a registered current-instruction stage and presents the current instruction split into op / cc / source / destination fields. Sits between instruction memory fetch and the control sequencer. Adds flow control, flush for branches, and overflow detection.

## Interface
- OP_W, 4, opcode field width
- CC_W, 4, condition-code field width
- ADDR_W, 12, source and destination address field width
- DEPTH, 4, queue entries, power of two, ≥2
- Derived: IW = OP_W+CC_W+2*ADDR_W (32 at defaults); LW = $clog2(DEPTH+1)
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  discard queue and current instruction
- ir_cmd  in  1  push strobe; ir_datain accepted when ir_cmd && ir_ready
- ir_datain  in  IW  fetched word: [IW-1 -: OP_W]=op, next CC_W=cc, next ADDR_W=s_a, low ADDR_W=de_a
- ir_ready  out  1  queue can accept a push (level < DEPTH)
- ir_next  in  1  sequencer consumes current instruction
- ir_valid  out  1  op/cc/s_a/de_a hold a valid instruction
- op  out  OP_W  current opcode
- cc  out  CC_W  current condition code
- s_a  out  ADDR_W  current source address
- de_a  out  ADDR_W  current destination address
- level  out  LW  queue occupancy, current-instruction stage excluded
- ovf  out  1  sticky: ir_cmd asserted while ir_ready low

## Operation
- Storage: DEPTH-entry circular queue (write/read pointers wrap modulo DEPTH) plus one current-instruction register. Total capacity DEPTH+1.
- Push: ir_cmd && ir_ready writes ir_datain at the write pointer; level increments.
- Load: when (!ir_valid || ir_next) and level>0, the head entry is loaded into the field registers, ir_valid=1, and level decrements.
- Consume: ir_next with no load source clears ir_valid; ir_next while ir_valid=0 is ignored.
- Push and load in the same cycle: level unchanged.
- Full: ir_ready=0 even if a load occurs that cycle. A push is never accepted on a full queue. A rejected ir_cmd sets ovf and drops the word.
- Flush: pointers reset, level=0, ir_valid=0, ovf cleared. Flush overrides a same-cycle push, ir_next and load. Field registers keep their stale values.
- Fields are written only on load; they hold their value otherwise.

## Timing
- Reset values: op=0, cc=0, s_a=0, de_a=0, ir_valid=0, level=0, ovf=0; ir_ready=1.
- Reset mid-operation clears all state immediately and asynchronously; queued words are lost.
- ir_ready is combinational from level only. It does not depend on ir_cmd or ir_next.
- Latency, empty queue, bypass off: word pushed at edge N is visible on the fields with ir_valid after edge N+1.
- Back-to-back throughput: one push and one consume per cycle, sustained.
- level and ovf update at the same edge as the event that causes them.

## Configuration
- IR_QUEUE_BYPASS_EN defined: if level==0 and (!ir_valid || ir_next), an accepted push loads ir_datain directly into the field registers at edge N, skipping the queue. Latency is 1 cycle, matching the legacy latch; level stays 0.
- Undefined: every word passes through the queue; minimum latency is 2 cycles.
- Flush priority and ovf rules are identical in both builds.

## Structure
- Shared package ir_pkg: default field-width constants (OP_W, CC_W, ADDR_W), derived IW, and field-slice functions (get_op, get_cc, get_sa, get_dea) parametrised on the widths. The control sequencer reuses these.
- Sub-module ir_fifo: pointers, storage array, level, and full/empty. Parameters are width IW and depth DEPTH; ports are push, pop, clr, din, dout, level.
- ir_queue contains ir_fifo, the field registers, the ir_valid/ovf logic and the bypass mux.

## Test plan
- Reset then idle: all outputs 0, ir_ready=1. Push 0x1A3C_5F01 → after 2 edges (1 with bypass): op=1, cc=A, s_a=0x3C5, de_a=0xF01, ir_valid=1.
- Fill: push 5 words with ir_next=0 → first word in fields, level=4, ir_ready=0. Sixth push → ovf=1, level stays 4, word dropped.
- Drain: after fill, hold ir_next=1 for 5 cycles → the words appear in push order, one per cycle, then ir_valid=0 and level=0.
- Streaming: push and ir_next every cycle for 20 words (bypass off) → level constant at 1, no gaps, no ovf.
- Flush with same-cycle push and ir_next at level=3 → level=0, ir_valid=0, ovf=0; the pushed word never appears.
- Assert reset mid-stream at level=2 → outputs return to reset values asynchronously, before the next edge.
